// File: rtl/irq_encoder16_pkg.sv
// Shared constants and FSM encoding for the 16-source interrupt encoder.
package irq_encoder16_pkg;
  localparam int N_SRC = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;
endpackage

// File: rtl/irq_encoder16_prio_enc16.sv
// Rotating priority encoder: first set bit of elig at or above start, wrapping 15 -> 0.
module prio_enc16
  import irq_encoder16_pkg::*;
(
  input  logic [N_SRC-1:0] elig,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] sel
);
  logic [N_SRC-1:0] rot;
  logic [IDX_W-1:0] low;

  // rot[i] is source (start + i) mod 16, so bit 0 is the highest-priority slot
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rot[i] = elig[IDX_W'(i) + start];
    end
  end

  always_comb begin
    found = 1'b0;
    low   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        low   = IDX_W'(i);
      end
    end
  end

  assign sel = low + start;
endmodule

// File: rtl/irq_encoder16.sv
// 16-line interrupt encoder: pending capture, masking, fixed/round-robin select, valid/ack hold.
module irq_encoder16
  import irq_encoder16_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter bit EDGE        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] mask,
  input  logic             ack,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_SRC-1:0] pending
);
  state_e           state_q;
  logic [IDX_W-1:0] idx_q, last_q;
  logic [N_SRC-1:0] pend_q, pend_d, req_q;
  logic [N_SRC-1:0] set_v, clr_v, elig;
  logic [IDX_W-1:0] start, sel;
  logic             found, accept;

  assign accept = (state_q == PRESENT) && ack;
  assign set_v  = EDGE ? (req & ~req_q) : req;
  assign clr_v  = accept ? ({{(N_SRC-1){1'b0}}, 1'b1} << idx_q) : '0;
  // set is OR-ed after the clear so a fresh event on the acked line survives
  assign pend_d = (pend_q & ~clr_v) | set_v;
  assign elig   = pend_q & ~mask;
  assign start  = ROUND_ROBIN ? IDX_W'(last_q + 1'b1) : '0;

  prio_enc16 u_prio (
    .elig  (elig),
    .start (start),
    .found (found),
    .sel   (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '1;
      pend_q  <= '0;
      req_q   <= '0;
    end else begin
      req_q  <= req;
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (found) begin
            idx_q   <= sel;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            last_q  <= idx_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid   = (state_q == PRESENT);
  assign idx     = idx_q;
  assign pending = pend_q;
endmodule

// File: tb/tb_irq_encoder16.sv
// Bench for irq_encoder16: directed table, corner sequences, randomized run vs. behavioural model.
module tb_irq_encoder16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0, mask = '0;
  logic        ack = 1'b0;

  logic        v_w [3];
  logic [3:0]  i_w [3];
  logic [15:0] p_w [3];

  // 0: fixed/edge, 1: round-robin/edge, 2: fixed/level
  irq_encoder16 #(.ROUND_ROBIN(1'b0), .EDGE(1'b1)) dut_fx (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .valid(v_w[0]), .idx(i_w[0]), .pending(p_w[0]));
  irq_encoder16 #(.ROUND_ROBIN(1'b1), .EDGE(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .valid(v_w[1]), .idx(i_w[1]), .pending(p_w[1]));
  irq_encoder16 #(.ROUND_ROBIN(1'b0), .EDGE(1'b0)) dut_lv (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .valid(v_w[2]), .idx(i_w[2]), .pending(p_w[2]));

  logic [15:0] pe_elig;
  logic [3:0]  pe_start, pe_sel;
  logic        pe_found;
  prio_enc16 u_pe (.elig(pe_elig), .start(pe_start), .found(pe_found), .sel(pe_sel));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mask = '0; ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] dec4to16(input logic [3:0] s);
    return 16'h0001 << s;
  endfunction

  // behavioural model state, one per instance
  logic [15:0] m_pend [3];
  logic [15:0] m_reqq [3];
  logic        m_val  [3];
  logic [3:0]  m_idx  [3];
  logic [3:0]  m_last [3];

  task automatic model_upd();
    for (int m = 0; m < 3; m++) begin
      bit rr, ed, picked;
      int pick, j;
      logic [15:0] np;
      rr = (m == 1); ed = (m != 2); picked = 0; pick = 0;
      if (rst) begin
        m_pend[m] = '0; m_reqq[m] = '0; m_val[m] = 1'b0; m_idx[m] = '0; m_last[m] = 4'd15;
      end else begin
        np = m_pend[m];
        if (m_val[m] && ack) np[m_idx[m]] = 1'b0;
        for (int i = 0; i < 16; i++)
          if (ed ? (req[i] && !m_reqq[m][i]) : req[i]) np[i] = 1'b1;
        if (!m_val[m]) begin
          for (int k = 0; k < 16; k++) begin
            j = rr ? (int'(m_last[m]) + 1 + k) % 16 : k;
            if (!picked && m_pend[m][j] && !mask[j]) begin picked = 1; pick = j; end
          end
          if (picked) begin m_val[m] = 1'b1; m_idx[m] = 4'(pick); end
        end else if (ack) begin
          m_last[m] = m_idx[m];
          m_val[m]  = 1'b0;
        end
        m_pend[m] = np;
        m_reqq[m] = req;
      end
    end
  endtask

  typedef struct {
    logic [15:0] req;
    logic        ack;
    logic        ev;
    logic [3:0]  ei;
    logic [15:0] ep;
  } vec_t;

  vec_t tbl [8];
  int   rr_exp [4];

  initial begin
    tbl[0] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000}; // ack with nothing valid
    tbl[1] = '{16'h8004, 1'b0, 1'b0, 4'd0,  16'h8004};
    tbl[2] = '{16'h8004, 1'b0, 1'b1, 4'd2,  16'h8004};
    tbl[3] = '{16'h8004, 1'b1, 1'b0, 4'd2,  16'h8000};
    tbl[4] = '{16'h8004, 1'b0, 1'b1, 4'd15, 16'h8000};
    tbl[5] = '{16'h8004, 1'b0, 1'b1, 4'd15, 16'h8000};
    tbl[6] = '{16'h8004, 1'b1, 1'b0, 4'd15, 16'h0000};
    tbl[7] = '{16'h0000, 1'b0, 1'b0, 4'd15, 16'h0000};
    rr_exp = '{1, 3, 9, 1};

    // reset state
    do_reset();
    chk("rst_valid", 32'(v_w[0]), 0);
    chk("rst_idx",   32'(i_w[0]), 0);
    chk("rst_pend",  32'(p_w[0]), 0);

    // fixed priority table
    for (int t = 0; t < 8; t++) begin
      req = tbl[t].req; ack = tbl[t].ack;
      step();
      chk($sformatf("tbl%0d_valid", t), 32'(v_w[0]), 32'(tbl[t].ev));
      chk($sformatf("tbl%0d_idx", t),   32'(i_w[0]), 32'(tbl[t].ei));
      chk($sformatf("tbl%0d_pend", t),  32'(p_w[0]), 32'(tbl[t].ep));
    end
    ack = 1'b0;

    // masking
    do_reset();
    mask = 16'h0004; req = 16'h0024;
    step();
    step();
    chk("mask_valid", 32'(v_w[0]), 1);
    chk("mask_idx5",  32'(i_w[0]), 5);
    mask = 16'h0000; ack = 1'b1;
    step();
    chk("mask_ack_pend", 32'(p_w[0]), 32'h0004);
    chk("mask_bubble",   32'(v_w[0]), 0);
    ack = 1'b0;
    step();
    chk("mask_idx2", 32'(i_w[0]), 2);
    mask = 16'hFFFF;
    step();
    step();
    chk("mask_hold_valid", 32'(v_w[0]), 1);
    chk("mask_hold_idx",   32'(i_w[0]), 2);
    ack = 1'b1; mask = 16'h0000; req = '0;
    step();
    ack = 1'b0;

    // round-robin ordering with re-pulsed sources
    do_reset();
    req = 16'h020A;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      int cur;
      cur = int'(i_w[1]);
      chk($sformatf("rr%0d_valid", k), 32'(v_w[1]), 1);
      chk($sformatf("rr%0d_idx", k),   32'(cur), 32'(rr_exp[k]));
      ack = 1'b1; req = '0;
      step();
      chk($sformatf("rr%0d_bubble", k), 32'(v_w[1]), 0);
      ack = 1'b0; req = 16'h0001 << cur;
      step();
    end
    req = '0;

    // set and clear on the same bit in one cycle
    do_reset();
    req = 16'h0010;
    step();
    step();
    chk("sc_idx4", 32'(i_w[0]), 4);
    req = '0;
    step();
    req = 16'h0010; ack = 1'b1;
    step();
    chk("sc_pend_kept", 32'(p_w[0]), 32'h0010);
    chk("sc_bubble",    32'(v_w[0]), 0);
    ack = 1'b0; req = '0;
    step();
    chk("sc_again_valid", 32'(v_w[0]), 1);
    chk("sc_again_idx",   32'(i_w[0]), 4);

    // reset during PRESENT, req held high across it
    do_reset();
    req = 16'h00F0;
    step();
    step();
    chk("mr_pend",  32'(p_w[0]), 32'h00F0);
    chk("mr_valid", 32'(v_w[0]), 1);
    rst = 1'b1;
    step();
    chk("mr_rst_valid", 32'(v_w[0]), 0);
    chk("mr_rst_pend",  32'(p_w[0]), 0);
    chk("mr_rst_idx",   32'(i_w[0]), 0);
    rst = 1'b0;
    step();
    chk("mr_recap_pend", 32'(p_w[0]), 32'h00F0);
    step();
    chk("mr_recap_idx", 32'(i_w[0]), 4);

    // standalone priority encoder vs. search model and one-hot decode
    for (int n = 0; n < 200; n++) begin
      int  ex;
      bit  ef;
      pe_elig  = (n % 8 == 0) ? 16'h0 : 16'($urandom & $urandom);
      pe_start = 4'($urandom_range(0, 15));
      ef = 0; ex = 0;
      for (int k = 15; k >= 0; k--)
        if (pe_elig[(int'(pe_start) + k) % 16]) begin ef = 1; ex = (int'(pe_start) + k) % 16; end
      #1;
      chk("pe_found", 32'(pe_found), 32'(ef));
      if (ef) begin
        chk("pe_sel", 32'(pe_sel), 32'(ex));
        chk("pe_dec", 32'((dec4to16(pe_sel) & pe_elig) != 0), 1);
      end
    end

    // randomized run, all three variants against the model
    rst = 1'b1; req = '0; mask = '0; ack = 1'b0;
    model_upd();
    step();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      req  = 16'($urandom & $urandom & $urandom);
      mask = 16'($urandom & $urandom);
      ack  = $urandom_range(0, 1) == 1;
      model_upd();
      step();
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("rnd%0d_valid", m), 32'(v_w[m]), 32'(m_val[m]));
        chk($sformatf("rnd%0d_idx", m),   32'(i_w[m]), 32'(m_idx[m]));
        chk($sformatf("rnd%0d_pend", m),  32'(p_w[m]), 32'(m_pend[m]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
